// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the operand-entry FSM encoding and key indices.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    // Operand entry walk: low/high halves of A and B, op select, then offer.
    typedef enum logic [2:0] {
        A_LO  = 3'd0,
        A_HI  = 3'd1,
        B_LO  = 3'd2,
        B_HI  = 3'd3,
        OPSEL = 3'd4,
        ISSUE = 3'd5
    } entry_state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_BACK  = 1;
    localparam int KEY_CLEAR = 2;
    localparam int KEY_SEXT  = 3;

    // Sign-extend a 16-bit switch value to a full operand word.
    function automatic word_t sext16(input logic sign, input logic [15:0] lo);
        return {{16{sign}}, lo};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and a registered
// one-cycle press pulse on a debounced 1->0 (active-low press) transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // Bring the asynchronous key into the clock domain; idle level is released (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key_raw};
    end

    // Count consecutive cycles of disagreement; accept the new level after
    // DEBOUNCE_CYCLES of them and flag a press only on the falling change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press_q  <= stable_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_operand_entry.sv
// Operand entry front end: debounced DE2 keys walk an FSM that assembles
// portA/portB from switch halves and an aluop, then offers them to the ALU.
//
// Handshake: op_valid is driven purely from state (never from op_ready).
// While op_valid=1, portA/portB/aluop are held constant. A transfer happens
// on the rising edge where op_valid & op_ready are both 1; op_valid drops on
// the following cycle. op_ready while op_valid=0 has no effect.
module alu_operand_entry
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         CLOCK_50,
    input  logic         RST,
    input  logic [3:0]   KEY,
    input  logic [17:0]  SW,
    output word_t        portA,
    output word_t        portB,
    output aluop_t       aluop,
    output logic         op_valid,
    input  logic         op_ready,
    output entry_state_t entry_state
);

    entry_state_t state_q;
    entry_state_t state_nxt;
    logic [3:0]   press;

    logic clr_regs;
    logic wr_a_lo, wr_a_hi, wr_b_lo, wr_b_hi;
    logic wr_a_full, wr_b_full, wr_op;

    logic unused_sw;
    assign unused_sw = SW[17];

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (CLOCK_50),
            .rst     (RST),
            .key_raw (KEY[k]),
            .press   (press[k])
        );
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) state_q <= A_LO;
        else     state_q <= state_nxt;
    end

    // Next state: ISSUE only leaves on a handshake; elsewhere one key action
    // is taken with priority clear > back > enter > sext.
    always_comb begin
        state_nxt = state_q;
        if (state_q == ISSUE) begin
            if (op_ready) state_nxt = A_LO;
        end else if (press[KEY_CLEAR]) begin
            state_nxt = A_LO;
        end else if (press[KEY_BACK]) begin
            case (state_q)
                A_HI:    state_nxt = A_LO;
                B_LO:    state_nxt = A_HI;
                B_HI:    state_nxt = B_LO;
                OPSEL:   state_nxt = B_HI;
                default: state_nxt = A_LO;
            endcase
        end else if (press[KEY_ENTER]) begin
            case (state_q)
                A_LO:    state_nxt = A_HI;
                A_HI:    state_nxt = B_LO;
                B_LO:    state_nxt = B_HI;
                B_HI:    state_nxt = OPSEL;
                OPSEL:   state_nxt = ISSUE;
                default: state_nxt = state_q;
            endcase
        end else if (press[KEY_SEXT]) begin
            case (state_q)
                A_LO:    state_nxt = B_LO;
                B_LO:    state_nxt = OPSEL;
                default: state_nxt = state_q;
            endcase
        end
    end

    // Outputs and datapath write strobes, decoded from the current state and
    // the same key priority as the next-state logic.
    always_comb begin
        op_valid    = (state_q == ISSUE);
        entry_state = state_q;
        clr_regs    = 1'b0;
        wr_a_lo     = 1'b0;
        wr_a_hi     = 1'b0;
        wr_b_lo     = 1'b0;
        wr_b_hi     = 1'b0;
        wr_a_full   = 1'b0;
        wr_b_full   = 1'b0;
        wr_op       = 1'b0;
        if (state_q != ISSUE) begin
            if (press[KEY_CLEAR]) begin
                clr_regs = 1'b1;
            end else if (press[KEY_BACK]) begin
                clr_regs = 1'b0;
            end else if (press[KEY_ENTER]) begin
                case (state_q)
                    A_LO:    wr_a_lo = 1'b1;
                    A_HI:    wr_a_hi = 1'b1;
                    B_LO:    wr_b_lo = 1'b1;
                    B_HI:    wr_b_hi = 1'b1;
                    OPSEL:   wr_op   = 1'b1;
                    default: wr_op   = 1'b0;
                endcase
            end else if (press[KEY_SEXT]) begin
                wr_a_full = (state_q == A_LO);
                wr_b_full = (state_q == B_LO);
            end
        end
    end

    // Operand registers: half-word writes touch only their half; sext loads the word.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            portA <= '0;
            portB <= '0;
            aluop <= '0;
        end else if (clr_regs) begin
            portA <= '0;
            portB <= '0;
            aluop <= '0;
        end else begin
            if (wr_a_lo)   portA[15:0]  <= SW[15:0];
            if (wr_a_hi)   portA[31:16] <= SW[15:0];
            if (wr_b_lo)   portB[15:0]  <= SW[15:0];
            if (wr_b_hi)   portB[31:16] <= SW[15:0];
            if (wr_a_full) portA        <= sext16(SW[16], SW[15:0]);
            if (wr_b_full) portB        <= sext16(SW[16], SW[15:0]);
            if (wr_op)     aluop        <= SW[3:0];
        end
    end

endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry with a short debounce window.
module tb_alu_operand_entry;
    import cpu_types_pkg::*;

    localparam int DB = 4;

    logic         CLOCK_50;
    logic         RST;
    logic [3:0]   KEY;
    logic [17:0]  SW;
    logic         op_ready;
    word_t        portA;
    word_t        portB;
    aluop_t       aluop;
    logic         op_valid;
    entry_state_t entry_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of offered operations {portA, portB, aluop}.
    logic [67:0] exp_q[$];

    // Reference model of the entry process.
    int          m_state;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;

    alu_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50    (CLOCK_50),
        .RST         (RST),
        .KEY         (KEY),
        .SW          (SW),
        .portA       (portA),
        .portB       (portB),
        .aluop       (aluop),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .entry_state (entry_state)
    );

    // Clock and watchdog.
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a     = '0;
        m_b     = '0;
        m_op    = '0;
    endtask

    // Apply one debounced key action to the model (clear > back > enter > sext).
    task automatic model_apply(input logic [3:0] mask, input logic [17:0] sw);
        if (m_state == 5) return;
        if (mask[2]) begin
            model_reset();
        end else if (mask[1]) begin
            if (m_state > 0) m_state = m_state - 1;
        end else if (mask[0]) begin
            case (m_state)
                0: m_a = {m_a[31:16], sw[15:0]};
                1: m_a = {sw[15:0], m_a[15:0]};
                2: m_b = {m_b[31:16], sw[15:0]};
                3: m_b = {sw[15:0], m_b[15:0]};
                default: m_op = sw[3:0];
            endcase
            m_state = m_state + 1;
            if (m_state == 5) exp_q.push_back({m_a, m_b, m_op});
        end else if (mask[3]) begin
            if (m_state == 0) begin
                m_a = sw[16] ? {16'hFFFF, sw[15:0]} : {16'h0000, sw[15:0]};
                m_state = 2;
            end else if (m_state == 2) begin
                m_b = sw[16] ? {16'hFFFF, sw[15:0]} : {16'h0000, sw[15:0]};
                m_state = 4;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " state"}, 68'(entry_state), 68'(m_state));
        check({tag, " portA"}, 68'(portA), 68'(m_a));
        check({tag, " portB"}, 68'(portB), 68'(m_b));
        check({tag, " aluop"}, 68'(aluop), 68'(m_op));
        check({tag, " op_valid"}, 68'(op_valid), 68'(m_state == 5));
    endtask

    // Hold keys (active-low) long enough to debounce, release, then compare.
    task automatic press(input string tag, input logic [3:0] mask, input logic [17:0] sw);
        SW  = sw;
        KEY = ~mask;
        repeat (8) tick();
        KEY = 4'hF;
        repeat (8) tick();
        model_apply(mask, sw);
        check_model(tag);
    endtask

    task automatic handshake();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        if (m_state == 5) m_state = 0;
        check_model("handshake");
    endtask

    // Monitor: every accepted transfer must match the oldest expected operation.
    always @(negedge CLOCK_50) begin
        if (!RST && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected transfer", {portA, portB, aluop}, 68'h0);
            end else begin
                check("transfer", {portA, portB, aluop}, exp_q.pop_front());
            end
        end
    end

    // Stimulus.
    initial begin
        int old_state;
        logic [3:0]  mask;
        logic [17:0] sw;

        RST = 1'b1; KEY = 4'hF; SW = '0; op_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        check_model("reset held");
        RST = 1'b0;
        repeat (2) tick();
        check_model("after reset");

        // Full entry.
        press("enter a_lo", 4'b0001, 18'h01234);
        press("enter a_hi", 4'b0001, 18'h0DEAD);
        press("enter b_lo", 4'b0001, 18'h00005);
        press("enter b_hi", 4'b0001, 18'h00000);
        press("enter op",   4'b0001, 18'h00002);
        check("full portA", portA, 68'hDEAD1234);
        check("full portB", portB, 68'h00000005);
        check("full aluop", aluop, 68'h2);
        check("full valid", op_valid, 68'h1);
        repeat (10) begin
            tick();
            check_model("hold");
        end
        press("lock clear", 4'b0100, 18'h3FFFF);
        press("lock back",  4'b0010, 18'h3FFFF);
        press("lock enter", 4'b0001, 18'h3FFFF);
        handshake();
        check("handshake state", entry_state, 68'(A_LO));

        // Sign-extended load and its restriction to LO states.
        press("sext a_lo", 4'b1000, 18'h18001);
        check("sext portA", portA, 68'hFFFF8001);
        check("sext state", entry_state, 68'(B_LO));
        press("back to a_hi", 4'b0010, 18'h0);
        press("sext a_hi",  4'b1000, 18'h1FFFF);

        // Short glitch: no press.
        SW = 18'h000AB;
        KEY = 4'hE;
        repeat (3) tick();
        KEY = 4'hF;
        repeat (10) tick();
        check_model("glitch");

        // Exact latency from the raw fall.
        old_state = m_state;
        KEY = 4'hE;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) check($sformatf("latency edge %0d", e), entry_state, 68'(old_state));
            else       check("latency edge 7", entry_state, 68'(old_state + 1));
        end
        tick();
        KEY = 4'hF;
        repeat (8) tick();
        model_apply(4'b0001, 18'h000AB);
        check_model("long press");

        // Bounce every cycle: nothing.
        for (int i = 0; i < 20; i++) begin
            KEY = (i % 2 == 0) ? 4'hE : 4'hF;
            tick();
        end
        KEY = 4'hF;
        repeat (10) tick();
        check_model("bounce");

        // Priority: enter and clear together from B_HI.
        press("pre clear", 4'b0100, 18'h0);
        press("pri a_lo", 4'b0001, 18'h0AAAA);
        press("pri a_hi", 4'b0001, 18'h0BBBB);
        press("pri b_lo", 4'b0001, 18'h0CCCC);
        press("pri both", 4'b0101, 18'h0DDDD);
        check("pri state", entry_state, 68'(A_LO));
        check("pri portA", portA, 68'h0);

        // Reset during a count: no press after release.
        press("pre rst", 4'b0001, 18'h05555);
        KEY = 4'hE;
        repeat (4) tick();
        RST = 1'b1;
        KEY = 4'hF;
        tick();
        model_reset();
        check_model("rst mid count");
        tick();
        RST = 1'b0;
        repeat (15) tick();
        check_model("after rst mid count");

        // Randomized entry sessions.
        for (int n = 0; n < 90; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: mask = 4'b0001;
                5, 6:          mask = 4'b1000;
                7:             mask = 4'b0010;
                8:             mask = 4'b0100;
                default:       mask = 4'($urandom_range(1, 15));
            endcase
            sw = 18'($urandom_range(0, 18'h3FFFF));
            press("rand", mask, sw);
            if (m_state == 5) begin
                repeat ($urandom_range(0, 6)) begin
                    tick();
                    check_model("rand hold");
                end
                if ($urandom_range(0, 1) == 1)
                    press("rand lock", 4'($urandom_range(1, 15)), 18'($urandom_range(0, 18'h3FFFF)));
                handshake();
            end
        end

        tick();
        check("scoreboard drained", 68'(exp_q.size()), 68'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
